// File: rtl/packet_to_message_pkg.sv
// Shared NIC constants and flit-type helpers for the packet_to_message receive stage.
// Values mirror NIC-defines.v, including the MSG_QUEUE_DEPTH entry that sizes the message queue.
package packet_to_message_pkg;

    localparam int FLIT_WIDTH        = 16;
    localparam int MAX_PACKET_LENGHT = 8;
    localparam int N_BITS_FLIT_TYPE  = 2;
    localparam int FLIT_TYPE_LSB     = FLIT_WIDTH - N_BITS_FLIT_TYPE;
    localparam int MSG_QUEUE_DEPTH   = 2;
    localparam int MSG_WIDTH         = MAX_PACKET_LENGHT * FLIT_WIDTH;

    // The flit type lives in the top N_BITS_FLIT_TYPE bits of every flit.
    typedef enum logic [N_BITS_FLIT_TYPE-1:0] {
        BODY_FLIT      = 2'b00,
        HEAD_FLIT      = 2'b01,
        TAIL_FLIT      = 2'b10,
        HEAD_TAIL_FLIT = 2'b11
    } flit_type_e;

    function automatic logic is_terminator(input flit_type_e t);
        return (t == TAIL_FLIT) || (t == HEAD_TAIL_FLIT);
    endfunction

    function automatic logic is_header(input flit_type_e t);
        return (t == HEAD_FLIT) || (t == HEAD_TAIL_FLIT);
    endfunction

endpackage

// File: rtl/packet_to_message_length_decoder.sv
// Combinational priority encoder: length = index of the lowest terminating flit + 1.
// With CHECK_EN set it also flags packets lacking a header in slot 0 or any terminator.
module packet_length_decoder
    import packet_to_message_pkg::*;
#(
    parameter int N_BITS_LENGTH = 4,
    parameter bit CHECK_EN      = 1'b0
) (
    input  logic [MSG_WIDTH-1:0]     in_link_i,
    output logic [N_BITS_LENGTH-1:0] length_o,
    output logic                     malformed_o
);

    logic found;
    logic head_ok;

    always_comb begin
        length_o = N_BITS_LENGTH'(MAX_PACKET_LENGHT);
        found    = 1'b0;
        // Scanning downward lets the lowest matching slot win.
        for (int i = MAX_PACKET_LENGHT - 1; i >= 0; i--) begin
            if (is_terminator(flit_type_e'(in_link_i[i*FLIT_WIDTH + FLIT_TYPE_LSB +: N_BITS_FLIT_TYPE]))) begin
                length_o = N_BITS_LENGTH'(i + 1);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        head_ok     = is_header(flit_type_e'(in_link_i[FLIT_TYPE_LSB +: N_BITS_FLIT_TYPE]));
        malformed_o = CHECK_EN && (!head_ok || !found);
    end

endmodule

// File: rtl/packet_to_message.sv
// Packet-to-message queue between the NoC reassembly buffer and the WISHBONE message consumer.
// Optional PKT2MSG_CHECK_EN drops malformed packets (still granted) and pulses malformed_o.
module packet_to_message
    import packet_to_message_pkg::*;
#(
    parameter int N_MSG          = MSG_QUEUE_DEPTH,
    parameter int N_BITS_MSG_PTR = 1,
    parameter int N_BITS_LENGTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r_pkt_to_msg_i,
    output logic                     g_pkt_to_msg_o,
    input  logic [MSG_WIDTH-1:0]     in_link_i,
    output logic                     r_msg_o,
    input  logic                     g_msg_i,
    output logic [MSG_WIDTH-1:0]     msg_o,
    output logic [N_BITS_LENGTH-1:0] msg_length_o,
    output logic                     malformed_o
);

    localparam int CNT_W = N_BITS_MSG_PTR + 1;
    localparam logic [N_BITS_MSG_PTR-1:0] LAST_PTR  = N_BITS_MSG_PTR'(N_MSG - 1);
    localparam logic [CNT_W-1:0]          DEPTH_CNT = CNT_W'(N_MSG);

`ifdef PKT2MSG_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic [N_BITS_MSG_PTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [N_BITS_MSG_PTR-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;

    logic [MSG_WIDTH-1:0]      msg_mem [N_MSG];
    logic [N_BITS_LENGTH-1:0]  len_mem [N_MSG];

    logic [N_BITS_LENGTH-1:0]  dec_length;
    logic                      dec_malformed;
    logic                      grant;
    logic                      push;
    logic                      pop;

    packet_length_decoder #(
        .N_BITS_LENGTH (N_BITS_LENGTH),
        .CHECK_EN      (CHECK_EN)
    ) u_length_decoder (
        .in_link_i   (in_link_i),
        .length_o    (dec_length),
        .malformed_o (dec_malformed)
    );

    // Grant ignores g_msg_i on purpose: a full queue never grants while popping.
    always_comb begin
        grant = r_pkt_to_msg_i && !rst && (count_q < DEPTH_CNT);
        push  = grant && !dec_malformed;
        pop   = r_msg_o && g_msg_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is intentionally not reset; r_msg_o qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            msg_mem[wr_ptr_q] <= in_link_i;
            len_mem[wr_ptr_q] <= dec_length;
        end
    end

    assign g_pkt_to_msg_o = grant;
    assign r_msg_o        = (count_q != '0);
    assign msg_o          = msg_mem[rd_ptr_q];
    assign msg_length_o   = len_mem[rd_ptr_q];

`ifdef PKT2MSG_CHECK_EN
    logic malformed_q, malformed_d;

    always_comb begin
        malformed_d = grant && dec_malformed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            malformed_q <= 1'b0;
        end else begin
            malformed_q <= malformed_d;
        end
    end

    assign malformed_o = malformed_q;
`else
    assign malformed_o = 1'b0;
`endif

endmodule

// File: tb/tb_packet_to_message.sv
// Directed self-checking bench for packet_to_message (N_MSG = 2, 16-bit flits, 8-flit packets).
module tb_packet_to_message;
    import packet_to_message_pkg::*;

    localparam int FW = FLIT_WIDTH;
    localparam int ML = MAX_PACKET_LENGHT;
    localparam int MW = ML * FW;

    logic          clk;
    logic          rst;
    logic          r_pkt_to_msg_i;
    logic          g_pkt_to_msg_o;
    logic [MW-1:0] in_link_i;
    logic          r_msg_o;
    logic          g_msg_i;
    logic [MW-1:0] msg_o;
    logic [3:0]    msg_length_o;
    logic          malformed_o;

    int n_cmp = 0;
    int n_bad = 0;

    packet_to_message #(
        .N_MSG          (2),
        .N_BITS_MSG_PTR (1),
        .N_BITS_LENGTH  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .r_pkt_to_msg_i (r_pkt_to_msg_i),
        .g_pkt_to_msg_o (g_pkt_to_msg_o),
        .in_link_i      (in_link_i),
        .r_msg_o        (r_msg_o),
        .g_msg_i        (g_msg_i),
        .msg_o          (msg_o),
        .msg_length_o   (msg_length_o),
        .malformed_o    (malformed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds a packet: n_flits==0 means head followed by bodies only (no terminator).
    // Slots past the first tail are also tails so the lowest match must win.
    function automatic logic [MW-1:0] mk_pkt(input int n_flits, input logic [7:0] tag);
        logic [MW-1:0] p;
        logic [1:0]    t;
        for (int k = 0; k < ML; k++) begin
            if (n_flits == 0)                t = (k == 0) ? 2'b01 : 2'b00;
            else if (n_flits == 1 && k == 0) t = 2'b11;
            else if (k == 0)                 t = 2'b01;
            else if (k < n_flits - 1)        t = 2'b00;
            else                             t = 2'b10;
            p[k*FW +: FW] = {t, 6'(k), tag};
        end
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; r_pkt_to_msg_i = 1'b1; g_msg_i = 1'b0; in_link_i = mk_pkt(1, 8'h11);
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b0) begin n_bad++; $display("FAIL rst_grant: got %b want 0", g_pkt_to_msg_o); end
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL rst_rmsg: got %b want 0", r_msg_o); end
        n_cmp++; if (malformed_o !== 1'b0) begin n_bad++; $display("FAIL rst_malformed: got %b want 0", malformed_o); end
        step();
        rst = 1'b0; r_pkt_to_msg_i = 1'b0;
    endtask

    task automatic test_head_tail();
        logic [MW-1:0] pa;
        pa = mk_pkt(1, 8'hA1);
        g_msg_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL empty_pop_rmsg: got %b want 0", r_msg_o); end
        step();
        g_msg_i = 1'b0; r_pkt_to_msg_i = 1'b1; in_link_i = pa;
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b1) begin n_bad++; $display("FAIL ht_grant: got %b want 1", g_pkt_to_msg_o); end
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL ht_rmsg_c0: got %b want 0", r_msg_o); end
        step();
        r_pkt_to_msg_i = 1'b0; in_link_i = '0;
        @(negedge clk);
        n_cmp++; if (r_msg_o !== 1'b1) begin n_bad++; $display("FAIL ht_rmsg_c1: got %b want 1", r_msg_o); end
        n_cmp++; if (msg_length_o !== 4'd1) begin n_bad++; $display("FAIL ht_len: got %0d want 1", msg_length_o); end
        n_cmp++; if (msg_o[FW-1:0] !== pa[FW-1:0]) begin n_bad++; $display("FAIL ht_slot0: got %h want %h", msg_o[FW-1:0], pa[FW-1:0]); end
        g_msg_i = 1'b1;
        step();
        g_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL ht_rmsg_after_pop: got %b want 0", r_msg_o); end
    endtask

    task automatic test_four_flit();
        logic [MW-1:0] pb;
        pb = mk_pkt(4, 8'hB4);
        step();
        r_pkt_to_msg_i = 1'b1; in_link_i = pb;
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b1) begin n_bad++; $display("FAIL ff_grant: got %b want 1", g_pkt_to_msg_o); end
        step();
        r_pkt_to_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (msg_length_o !== 4'd4) begin n_bad++; $display("FAIL ff_len: got %0d want 4", msg_length_o); end
        n_cmp++; if (msg_o !== pb) begin n_bad++; $display("FAIL ff_msg: got %h want %h", msg_o, pb); end
        step();
        g_msg_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (r_msg_o !== 1'b1) begin n_bad++; $display("FAIL ff_rmsg_c2: got %b want 1", r_msg_o); end
        step();
        g_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL ff_rmsg_c3: got %b want 0", r_msg_o); end
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] pa, pb, pc;
        pa = mk_pkt(2, 8'hC1);
        pb = mk_pkt(3, 8'hC2);
        pc = mk_pkt(1, 8'hC3);
        step();
        r_pkt_to_msg_i = 1'b1; in_link_i = pa;
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b1) begin n_bad++; $display("FAIL b2b_grant_c0: got %b want 1", g_pkt_to_msg_o); end
        step();
        in_link_i = pb;
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b1) begin n_bad++; $display("FAIL b2b_grant_c1: got %b want 1", g_pkt_to_msg_o); end
        n_cmp++; if (msg_length_o !== 4'd2) begin n_bad++; $display("FAIL b2b_len_a: got %0d want 2", msg_length_o); end
        step();
        in_link_i = pc;
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b0) begin n_bad++; $display("FAIL b2b_grant_full: got %b want 0", g_pkt_to_msg_o); end
        step();
        g_msg_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b0) begin n_bad++; $display("FAIL b2b_grant_popping: got %b want 0", g_pkt_to_msg_o); end
        n_cmp++; if (msg_o !== pa) begin n_bad++; $display("FAIL b2b_msg_a: got %h want %h", msg_o, pa); end
        step();
        g_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b1) begin n_bad++; $display("FAIL b2b_grant_after_pop: got %b want 1", g_pkt_to_msg_o); end
        n_cmp++; if (msg_o !== pb) begin n_bad++; $display("FAIL b2b_msg_b: got %h want %h", msg_o, pb); end
        n_cmp++; if (msg_length_o !== 4'd3) begin n_bad++; $display("FAIL b2b_len_b: got %0d want 3", msg_length_o); end
        step();
        r_pkt_to_msg_i = 1'b0; g_msg_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (msg_o !== pb) begin n_bad++; $display("FAIL b2b_msg_b_hold: got %h want %h", msg_o, pb); end
        step();
        @(negedge clk);
        n_cmp++; if (msg_o !== pc) begin n_bad++; $display("FAIL b2b_msg_c: got %h want %h", msg_o, pc); end
        n_cmp++; if (msg_length_o !== 4'd1) begin n_bad++; $display("FAIL b2b_len_c: got %0d want 1", msg_length_o); end
        step();
        g_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", r_msg_o); end
    endtask

    task automatic test_push_pop_same();
        logic [MW-1:0] pd, pe;
        pd = mk_pkt(2, 8'hD1);
        pe = mk_pkt(5, 8'hE1);
        step();
        r_pkt_to_msg_i = 1'b1; in_link_i = pd;
        step();
        in_link_i = pe; g_msg_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b1) begin n_bad++; $display("FAIL pp_grant: got %b want 1", g_pkt_to_msg_o); end
        n_cmp++; if (msg_o !== pd) begin n_bad++; $display("FAIL pp_msg_d: got %h want %h", msg_o, pd); end
        step();
        r_pkt_to_msg_i = 1'b0; g_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (msg_o !== pe) begin n_bad++; $display("FAIL pp_msg_e: got %h want %h", msg_o, pe); end
        n_cmp++; if (msg_length_o !== 4'd5) begin n_bad++; $display("FAIL pp_len_e: got %0d want 5", msg_length_o); end
        step();
        g_msg_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (r_msg_o !== 1'b1) begin n_bad++; $display("FAIL pp_rmsg: got %b want 1", r_msg_o); end
        step();
        g_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL pp_count_one: got %b want 0", r_msg_o); end
    endtask

    task automatic test_reset_mid();
        logic [MW-1:0] ph;
        ph = mk_pkt(4, 8'hF4);
        step();
        r_pkt_to_msg_i = 1'b1; in_link_i = mk_pkt(3, 8'hF1);
        step();
        in_link_i = mk_pkt(2, 8'hF2);
        step();
        in_link_i = mk_pkt(1, 8'hF3);
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b0) begin n_bad++; $display("FAIL rm_full_grant: got %b want 0", g_pkt_to_msg_o); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL rm_rmsg_async: got %b want 0", r_msg_o); end
        n_cmp++; if (g_pkt_to_msg_o !== 1'b0) begin n_bad++; $display("FAIL rm_grant_async: got %b want 0", g_pkt_to_msg_o); end
        step();
        rst = 1'b0; in_link_i = ph;
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b1) begin n_bad++; $display("FAIL rm_grant_after: got %b want 1", g_pkt_to_msg_o); end
        step();
        r_pkt_to_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (msg_o !== ph) begin n_bad++; $display("FAIL rm_msg_h: got %h want %h", msg_o, ph); end
        n_cmp++; if (msg_length_o !== 4'd4) begin n_bad++; $display("FAIL rm_len_h: got %0d want 4", msg_length_o); end
        g_msg_i = 1'b1;
        step();
        g_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL rm_drained: got %b want 0", r_msg_o); end
    endtask

    task automatic test_malformed();
        logic [MW-1:0] pbad, pnt;
        pbad = mk_pkt(2, 8'h5A);
        pbad[FW-1 -: 2] = 2'b00;
        pnt = mk_pkt(0, 8'h6B);
        step();
        r_pkt_to_msg_i = 1'b1; in_link_i = pbad;
        @(negedge clk);
        n_cmp++; if (g_pkt_to_msg_o !== 1'b1) begin n_bad++; $display("FAIL mf_grant: got %b want 1", g_pkt_to_msg_o); end
        step();
        in_link_i = pnt;
`ifdef PKT2MSG_CHECK_EN
        @(negedge clk);
        n_cmp++; if (malformed_o !== 1'b1) begin n_bad++; $display("FAIL mf_pulse: got %b want 1", malformed_o); end
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL mf_rmsg: got %b want 0", r_msg_o); end
        step();
        r_pkt_to_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (malformed_o !== 1'b1) begin n_bad++; $display("FAIL mf_notail_pulse: got %b want 1", malformed_o); end
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL mf_notail_rmsg: got %b want 0", r_msg_o); end
        step();
        @(negedge clk);
        n_cmp++; if (malformed_o !== 1'b0) begin n_bad++; $display("FAIL mf_pulse_end: got %b want 0", malformed_o); end
`else
        @(negedge clk);
        n_cmp++; if (malformed_o !== 1'b0) begin n_bad++; $display("FAIL mf_tied: got %b want 0", malformed_o); end
        n_cmp++; if (msg_o !== pbad) begin n_bad++; $display("FAIL mf_enq_msg: got %h want %h", msg_o, pbad); end
        n_cmp++; if (msg_length_o !== 4'd2) begin n_bad++; $display("FAIL mf_enq_len: got %0d want 2", msg_length_o); end
        step();
        r_pkt_to_msg_i = 1'b0; g_msg_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (msg_o !== pbad) begin n_bad++; $display("FAIL mf_head_hold: got %h want %h", msg_o, pbad); end
        step();
        @(negedge clk);
        n_cmp++; if (msg_o !== pnt) begin n_bad++; $display("FAIL mf_notail_msg: got %h want %h", msg_o, pnt); end
        n_cmp++; if (msg_length_o !== 4'd8) begin n_bad++; $display("FAIL mf_notail_len: got %0d want 8", msg_length_o); end
        step();
        g_msg_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (r_msg_o !== 1'b0) begin n_bad++; $display("FAIL mf_drained: got %b want 0", r_msg_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_head_tail();
        test_four_flit();
        test_back_to_back();
        test_push_pop_same();
        test_reset_mid();
        test_malformed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
